// File: rtl/qfn_request_driver.sv
// qfn_request_driver: buffers Q-function operand requests, issues each to top_QFunction
// with a timed inform_valid pulse, and returns the captured Q. QDRV_STATS_EN adds done/drop counters.
module qfn_request_driver #(
    parameter int DATA_W         = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int PULSE_CYCLES   = 2,
    parameter int RESULT_LATENCY = 24
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_x,
    input  logic [DATA_W-1:0] s_t,
    input  logic [DATA_W-1:0] s_n,
    input  logic [DATA_W-1:0] s_alpha,
    output logic [DATA_W-1:0] q_x,
    output logic [DATA_W-1:0] q_t,
    output logic [DATA_W-1:0] q_n,
    output logic [DATA_W-1:0] q_alpha,
    output logic              q_inform_valid,
    input  logic [DATA_W-1:0] q_result,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_q,
`ifdef QDRV_STATS_EN
    output logic [15:0]       done_count,
    output logic [15:0]       drop_count,
`endif
    output logic              busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(RESULT_LATENCY + 1);
    localparam int OW = 4 * DATA_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t            state_q, state_d;
    logic [OW-1:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]       count_q, count_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [OW-1:0]     ops_q, ops_d;
    logic [DATA_W-1:0] m_q_q, m_q_d;
    logic              s_ready_q, s_ready_d;
    logic              inform_q, inform_d;
    logic              m_valid_q, m_valid_d;
    logic              push, pop;

    always_comb begin
        push      = s_valid && s_ready_q;
        pop       = (state_q == IDLE) && (count_q != '0);
        wr_d      = push ? wr_q + 1'b1 : wr_q;
        rd_d      = pop ? rd_q + 1'b1 : rd_q;
        count_d   = count_q + (PW+1)'(push) - (PW+1)'(pop);
        s_ready_d = count_d != (PW+1)'(FIFO_DEPTH);
        state_d   = state_q;
        cnt_d     = cnt_q;
        ops_d     = ops_q;
        m_valid_d = m_valid_q;
        m_q_d     = m_q_q;
        case (state_q)
            IDLE: if (pop) begin
                ops_d   = mem_q[rd_q];
                cnt_d   = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(PULSE_CYCLES - 1)) ? WAIT : ISSUE;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(RESULT_LATENCY - 1)) begin
                    m_q_d     = q_result;
                    m_valid_d = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: if (m_ready) begin
                m_valid_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        inform_d = state_d == ISSUE;
    end

    // Storage is not reset: emptiness is carried entirely by count_q.
    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_q] <= {s_x, s_t, s_n, s_alpha};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            cnt_q     <= '0;
            ops_q     <= '0;
            m_q_q     <= '0;
            s_ready_q <= 1'b1;
            inform_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            cnt_q     <= cnt_d;
            ops_q     <= ops_d;
            m_q_q     <= m_q_d;
            s_ready_q <= s_ready_d;
            inform_q  <= inform_d;
            m_valid_q <= m_valid_d;
        end
    end

`ifdef QDRV_STATS_EN
    logic [15:0] done_q, done_d, drop_q, drop_d;

    always_comb begin
        done_d = done_q + 16'(m_valid_q && m_ready);
        drop_d = (s_valid && !s_ready_q && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            done_q <= '0;
            drop_q <= '0;
        end else begin
            done_q <= done_d;
            drop_q <= drop_d;
        end
    end

    assign done_count = done_q;
    assign drop_count = drop_q;
`endif

    assign {q_x, q_t, q_n, q_alpha} = ops_q;
    assign q_inform_valid = inform_q;
    assign s_ready        = s_ready_q;
    assign m_valid        = m_valid_q;
    assign m_q            = m_q_q;
    assign busy           = (count_q != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_qfn_request_driver.sv
// tb_qfn_request_driver: randomized scenarios checked against a queue/timer reference model.
module tb_qfn_request_driver;
    localparam int DW = 32, DEPTH = 4, P = 2, L = 24;

    typedef struct packed {
        logic [DW-1:0] x, t, n, a;
    } req_t;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic          s_valid = 0, m_ready = 0;
    logic [DW-1:0] s_x = 0, s_t = 0, s_n = 0, s_alpha = 0, q_result = 0;
    logic          s_ready, q_inform_valid, m_valid, busy;
    logic [DW-1:0] q_x, q_t, q_n, q_alpha, m_q;
`ifdef QDRV_STATS_EN
    logic [15:0]   done_count, drop_count;
`endif

    int checks = 0, errors = 0;
    bit stub_rand = 0;

    qfn_request_driver #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .PULSE_CYCLES(P), .RESULT_LATENCY(L)) dut (
        .aclk(clk), .aresetn(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_x(s_x), .s_t(s_t), .s_n(s_n), .s_alpha(s_alpha),
        .q_x(q_x), .q_t(q_t), .q_n(q_n), .q_alpha(q_alpha),
        .q_inform_valid(q_inform_valid), .q_result(q_result),
        .m_valid(m_valid), .m_ready(m_ready), .m_q(m_q),
`ifdef QDRV_STATS_EN
        .done_count(done_count), .drop_count(drop_count),
`endif
        .busy(busy)
    );

    // Stub datapath: new Q value every cycle when randomized.
    always @(negedge clk) if (stub_rand) q_result = $urandom;

    // Reference model: a FIFO queue, one outstanding request timed by elapsed cycles.
    req_t          fq[$];
    bit            m_active, m_mv, m_sr, m_inf, m_busy;
    int            m_t, m_done, m_drop;
    req_t          m_ops;
    logic [DW-1:0] m_mq;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            m_active = 0; m_mv = 0; m_sr = 1; m_t = 0; m_ops = '0; m_mq = '0;
            m_done = 0; m_drop = 0; m_inf = 0; m_busy = 0;
        end else begin
            automatic bit pu = s_valid && m_sr;
            if (s_valid && !m_sr && m_drop < 65535) m_drop++;
            if (m_mv && m_ready) m_done = (m_done + 1) % 65536;
            if (m_active) begin
                if (m_t == L - 1) begin
                    m_mv = 1; m_mq = q_result; m_active = 0;
                end else m_t++;
            end else if (m_mv) begin
                if (m_ready) m_mv = 0;
            end else if (fq.size() > 0) begin
                m_ops = fq.pop_front(); m_active = 1; m_t = 0;
            end
            if (pu) fq.push_back(req_t'({s_x, s_t, s_n, s_alpha}));
            m_sr   = fq.size() < DEPTH;
            m_inf  = m_active && m_t < P;
            m_busy = fq.size() != 0 || m_active || m_mv;
        end
    end

    function automatic req_t rand_req();
        return req_t'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    task automatic set_req(input req_t r);
        {s_x, s_t, s_n, s_alpha} = r;
    endtask

    task automatic test_reset();
        rst_n = 0; s_valid = 0; m_ready = 0;
        repeat (3) @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
        checks++; if (q_inform_valid !== 1'b0) begin errors++; $display("FAIL reset_inform got %b exp 0", q_inform_valid); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
        checks++; if (m_q !== '0) begin errors++; $display("FAIL reset_m_q got %h exp 0", m_q); end
        checks++; if ({q_x, q_t, q_n, q_alpha} !== '0) begin errors++; $display("FAIL reset_ops got %h exp 0", {q_x, q_t, q_n, q_alpha}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int first = -1, rise = -1, pulses = 0;
        req_t r = req_t'({32'd32, 32'd55, 32'd101, 32'd2});
        stub_rand = 0; q_result = 32'h42C80000; m_ready = 1;
        s_valid = 1; set_req(r);
        @(negedge clk);
        s_valid = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            checks++; if (q_inform_valid !== m_inf) begin errors++; $display("FAIL single_inform c=%0d got %b exp %b", c, q_inform_valid, m_inf); end
            checks++; if (m_valid !== m_mv) begin errors++; $display("FAIL single_m_valid c=%0d got %b exp %b", c, m_valid, m_mv); end
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy, m_busy); end
            if (q_inform_valid && first < 0) first = c;
            if (q_inform_valid) pulses++;
            if (m_valid && rise < 0) begin
                rise = c;
                checks++; if (m_q !== 32'h42C80000) begin errors++; $display("FAIL single_m_q got %h exp 42c80000", m_q); end
            end
        end
        checks++; if ({q_x, q_t, q_n, q_alpha} !== r) begin errors++; $display("FAIL single_ops got %h exp %h", {q_x, q_t, q_n, q_alpha}, r); end
        checks++; if (pulses != P) begin errors++; $display("FAIL single_pulse_len got %0d exp %0d", pulses, P); end
        checks++; if (first < 0 || rise < 0 || rise - first != L) begin errors++; $display("FAIL single_latency got %0d exp %0d", rise - first, L); end
    endtask

    task automatic test_burst();
        req_t rq[5];
        int idx = 0, hs = 0, last = -1, c = 0;
        bit saw_full = 0;
        stub_rand = 1; m_ready = 1;
        foreach (rq[i]) rq[i] = rand_req();
        while (hs < 5 && c < 400) begin
            @(negedge clk); c++;
            checks++; if (s_ready !== m_sr) begin errors++; $display("FAIL burst_s_ready c=%0d got %b exp %b", c, s_ready, m_sr); end
            checks++; if (q_inform_valid !== m_inf) begin errors++; $display("FAIL burst_inform c=%0d got %b exp %b", c, q_inform_valid, m_inf); end
            checks++; if (m_valid !== m_mv) begin errors++; $display("FAIL burst_m_valid c=%0d got %b exp %b", c, m_valid, m_mv); end
            checks++; if ({q_x, q_t, q_n, q_alpha} !== m_ops) begin errors++; $display("FAIL burst_ops c=%0d got %h exp %h", c, {q_x, q_t, q_n, q_alpha}, m_ops); end
            if (!m_sr) saw_full = 1;
            if (m_valid) begin
                checks++; if (m_q !== m_mq) begin errors++; $display("FAIL burst_m_q c=%0d got %h exp %h", c, m_q, m_mq); end
                if (last >= 0) begin
                    checks++; if (c - last != L + 2) begin errors++; $display("FAIL burst_spacing got %0d exp %0d", c - last, L + 2); end
                end
                last = c; hs++;
            end
            if (idx < 5) begin
                s_valid = 1; set_req(rq[idx]);
                if (m_sr) idx++;
            end else s_valid = 0;
        end
        s_valid = 0;
        checks++; if (hs != 5) begin errors++; $display("FAIL burst_timeout got %0d results exp 5", hs); end
        checks++; if (!saw_full) begin errors++; $display("FAIL burst_full_seen got 0 exp 1"); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int idx = 0;
        bit got = 0;
        logic [DW-1:0] held;
        stub_rand = 1; m_ready = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (m_valid) begin got = 1; break; end
            if (idx < 2) begin s_valid = 1; set_req(rand_req()); if (m_sr) idx++; end
            else s_valid = 0;
        end
        s_valid = 0;
        checks++; if (!got || !m_mv) begin errors++; $display("FAIL bp_wait got %b exp 1", got); end
        held = m_mq;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++; if (m_valid !== 1'b1 || m_q !== held) begin errors++; $display("FAIL bp_hold c=%0d got %b/%h exp 1/%h", c, m_valid, m_q, held); end
            checks++; if (q_inform_valid !== 1'b0) begin errors++; $display("FAIL bp_no_issue c=%0d got %b exp 0", c, q_inform_valid); end
        end
        m_ready = 1;
        @(negedge clk);
        checks++; if (q_inform_valid !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL bp_release1 got %b/%b exp 0/0", q_inform_valid, m_valid); end
        @(negedge clk);
        checks++; if (q_inform_valid !== 1'b1) begin errors++; $display("FAIL bp_release2 got %b exp 1", q_inform_valid); end
        for (int c = 0; c < 100 && m_busy; c++) begin
            @(negedge clk);
            checks++; if (m_valid !== m_mv || m_q !== m_mq) begin errors++; $display("FAIL bp_drain got %b/%h exp %b/%h", m_valid, m_q, m_mv, m_mq); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        stub_rand = 1; m_ready = 1;
        s_valid = 1; set_req(rand_req());
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            s_valid = 0;
            if (m_active && m_t == 10) begin hit = 1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL rmid_reach_wait got 0 exp 1"); end
        #2 rst_n = 0;
        #1;
        checks++; if (q_inform_valid !== 0 || m_valid !== 0 || busy !== 0 || s_ready !== 1) begin
            errors++; $display("FAIL rmid_async got inf=%b mv=%b busy=%b sr=%b exp 0/0/0/1", q_inform_valid, m_valid, busy, s_ready); end
        checks++; if ({q_x, q_t, q_n, q_alpha, m_q} !== '0) begin errors++; $display("FAIL rmid_data got %h exp 0", {q_x, q_t, q_n, q_alpha, m_q}); end
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++; if (m_valid !== 1'b0 || q_inform_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rmid_after c=%0d got mv=%b inf=%b busy=%b exp 0", c, m_valid, q_inform_valid, busy); end
        end
    endtask

    task automatic test_stability();
        req_t r = rand_req();
        bit got = 0;
        stub_rand = 1; m_ready = 1;
        s_valid = 1; set_req(r);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            s_valid = 0; set_req(rand_req());
            if (m_active && m_t >= P) begin
                checks++; if ({q_x, q_t, q_n, q_alpha} !== r) begin errors++; $display("FAIL stab_ops c=%0d got %h exp %h", c, {q_x, q_t, q_n, q_alpha}, r); end
            end
            if (m_valid) begin
                got = 1;
                checks++; if (m_q !== m_mq) begin errors++; $display("FAIL stab_m_q got %h exp %h", m_q, m_mq); end
                break;
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL stab_timeout got 0 exp 1"); end
        repeat (3) @(negedge clk);
    endtask

`ifdef QDRV_STATS_EN
    task automatic test_stats();
        int idx = 0, before;
        stub_rand = 1; m_ready = 1;
        rst_n = 0; @(negedge clk); rst_n = 1;
        for (int c = 0; c < 300 && (idx < 5 || m_busy); c++) begin
            @(negedge clk);
            if (idx < 5) begin s_valid = 1; set_req(rand_req()); if (m_sr) idx++; end
            else s_valid = 0;
        end
        s_valid = 0;
        @(negedge clk);
        checks++; if (done_count !== 16'd5 || m_done != 5) begin errors++; $display("FAIL stats_done got %0d exp 5", done_count); end
        m_ready = 0; idx = 0;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            @(negedge clk);
            s_valid = 1; set_req(rand_req()); if (m_sr) idx++;
        end
        s_valid = 0;
        @(negedge clk);
        checks++; if (s_ready !== 1'b0 || m_sr) begin errors++; $display("FAIL stats_full got %b exp 0", s_ready); end
        before = m_drop;
        s_valid = 1;
        repeat (3) @(negedge clk);
        s_valid = 0;
        @(negedge clk);
        checks++; if (drop_count !== 16'(before + 3) || m_drop != before + 3) begin errors++; $display("FAIL stats_drop got %0d exp %0d", drop_count, before + 3); end
        m_ready = 1;
        for (int c = 0; c < 300 && m_busy; c++) @(negedge clk);
        checks++; if (busy !== 1'b0 || done_count !== 16'(m_done)) begin errors++; $display("FAIL stats_drain got busy=%b done=%0d exp 0/%0d", busy, done_count, m_done); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_reset_mid();
        test_stability();
`ifdef QDRV_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
